// File: rtl/sensor_frame_tx.sv
// Frame serializer: captures an NBYTES-wide sensor word and pushes it MSB byte first
// into a TX FIFO, as raw bytes or uppercase ASCII hex, with optional checksum and CR/LF.
module sensor_frame_tx #(
  parameter int NBYTES    = 5,
  parameter bit CHECK_EN  = 1'b1,
  parameter bit TERM_EN   = 1'b1,
  parameter bit ZERO_DROP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [8*NBYTES-1:0]   i_data,
  input  logic                  i_mode,
  input  logic                  i_full,
  output logic                  o_wr,
  output logic [7:0]            o_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_ovr
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HI, S_LO, S_CR, S_LF, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovr_q, ovr_d;

  logic [7:0]      top_byte;
  logic [7:0]      psum [NBYTES];
  logic            adv;
  logic            wr;
  logic            err;
  logic [7:0]      wdata;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  assign top_byte = shift_q[W-1 -: 8];

  // Running checksum over bytes 1..NBYTES-1 of the latched word; psum[NBYTES-1] is the total.
  assign psum[0] = 8'd0;
  generate
    for (genvar gi = 1; gi < NBYTES; gi++) begin : g_sum
      assign psum[gi] = psum[gi-1] + shift_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    ovr_d   = i_valid && (state_q != S_IDLE);
    adv     = 1'b0;
    wr      = 1'b0;
    err     = 1'b0;
    wdata   = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (i_valid && !(ZERO_DROP && (i_data == '0))) begin
          shift_d = i_data;
          mode_d  = i_mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = CW'(NBYTES - 1);
        if (CHECK_EN && (psum[NBYTES-1] != shift_q[7:0])) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_HI;
        end
      end
      S_HI: begin
        wdata = mode_q ? hex_ascii(top_byte[7:4]) : top_byte;
        wr    = !i_full;
        if (!i_full) begin
          if (mode_q) state_d = S_LO;
          else        adv     = 1'b1;
        end
      end
      S_LO: begin
        wdata = hex_ascii(top_byte[3:0]);
        wr    = !i_full;
        adv   = !i_full;
      end
      S_CR: begin
        wdata = 8'h0D;
        wr    = !i_full;
        if (!i_full) state_d = S_LF;
      end
      S_LF: begin
        wdata = 8'h0A;
        wr    = !i_full;
        if (!i_full) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Byte advance after the last nibble/byte of the current top byte was pushed.
    if (adv) begin
      if (cnt_q == '0) begin
        state_d = TERM_EN ? S_CR : S_DONE;
      end else begin
        shift_d = shift_q << 8;
        cnt_d   = cnt_q - 1'b1;
        state_d = S_HI;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_wr    = wr;
  assign o_wdata = wdata;
  assign o_err   = err;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = (state_q == S_DONE);
  assign o_ovr   = ovr_q;

endmodule

// File: doc/sensor_frame_tx.md
# sensor_frame_tx

Parametrised frame serializer between a sensor-data source (e.g. the DHT humidity/temperature reader) and the UART TX FIFO. On a one-cycle `i_valid` it captures an NBYTES-wide word and optionally verifies its trailing checksum. It then pushes the word into the FIFO MSB byte first, as raw bytes or uppercase ASCII hex, optionally followed by CR/LF. It honours FIFO full back-pressure and reports overrun and checksum errors.

## Interface
- NBYTES, 5, number of bytes in the input word; at least 1, and at least 2 when CHECK_EN=1
- CHECK_EN, 1, 1 = LSB byte must equal the mod-256 sum of the other bytes
- TERM_EN, 1, 1 = append 0x0D, 0x0A after each frame
- ZERO_DROP, 1, 1 = all-zero word with i_valid is ignored silently

- clk  in  1  system clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  one-cycle capture strobe
- i_data  in  8*NBYTES  sensor word; byte NBYTES-1 is sent first
- i_mode  in  1  0 = raw bytes, 1 = ASCII hex; sampled with i_valid
- i_full  in  1  TX FIFO full
- o_wr  out  1  FIFO push strobe
- o_wdata  out  8  FIFO push data
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when a frame is complete
- o_err  out  1  one-cycle pulse on checksum mismatch
- o_ovr  out  1  one-cycle pulse when i_valid arrives while not IDLE

## Operation
- States: IDLE, LOAD, HI, LO, CR, LF, DONE.
- IDLE:
  - i_valid=1 latches i_data into the shift register and i_mode into the mode register, then goes to LOAD.
  - If ZERO_DROP=1 and i_data==0, the strobe is ignored and the block stays in IDLE.
- LOAD:
  - CHECK_EN=1 and checksum mismatch: o_err=1 this cycle, go to IDLE, no push.
  - Otherwise go to HI.
  - The byte counter is loaded with NBYTES-1.
- HI:
  - Raw mode: o_wdata = shift register top byte.
  - Hex mode: o_wdata = ASCII of the top byte's high nibble; 0-9 maps to 0x30-0x39, A-F maps to 0x41-0x46.
  - On push, raw mode advances the byte; hex mode goes to LO.
- LO (hex mode only): o_wdata = ASCII of the low nibble; on push, advance the byte.
- Advance byte:
  - If the counter is 0, go to CR when TERM_EN=1, else to DONE.
  - Otherwise shift the register left 8 bits, decrement the counter, and return to HI.
- CR pushes 0x0D and then goes to LF. LF pushes 0x0A and then goes to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Push rule:
  - o_wr = (state is HI, LO, CR or LF) and !i_full, combinational.
  - A push happens on every cycle with o_wr=1.
  - With i_full=1 the state, o_wdata and the registers hold; no byte is lost or duplicated.
- Checksum: 8-bit wrapping sum of bytes NBYTES-1..1, compared against byte 0.
- Overrun:
  - i_valid in any state other than IDLE gives o_ovr=1 on the next cycle.
  - The in-flight frame is unaffected and the new data is discarded.
  - A strobe in DONE is also an overrun.

## Timing
- Reset values:
  - State IDLE; all registers 0.
  - o_wr, o_wdata, o_busy, o_done, o_err, o_ovr all 0.
  - Reset mid-frame abandons the frame immediately. Bytes already pushed stay in the FIFO.
- i_valid accepted at cycle 0: LOAD at cycle 1, first push at cycle 2 if not full.
- Raw mode, never full: pushes on cycles 2..NBYTES+1, plus 2 cycles for CR/LF.
  - o_done follows the last push by 1 cycle.
  - Earliest next accept is the cycle after o_done.
- Hex mode: 2*NBYTES data pushes.
- Each full cycle adds exactly one cycle of latency.
- o_busy is high from cycle 1 through the DONE cycle inclusive.

## Test plan
- Raw mode, NBYTES=5, i_data=0x3C00190055, i_full=0:
  - o_wr on cycles 2-8 with o_wdata 3C,00,19,00,55,0D,0A.
  - o_done at cycle 9.
  - o_busy low at cycle 10.
- Hex mode, same data:
  - 12 pushes: 33,43,30,30,31,39,30,30,35,35,0D,0A.
  - o_done one cycle after the last push.
- i_data=0x3C00190056, CHECK_EN=1:
  - o_err pulse at cycle 1, no o_wr, IDLE at cycle 2.
- Raw mode, i_full high on cycles 3-5:
  - Pushes at cycles 2 and 6 onward, with byte 00 held through 3-5 and pushed once.
  - Sequence otherwise identical; o_done at cycle 12.
- i_valid with 0x1111111133 at cycle 4 during a frame:
  - o_ovr at cycle 5; the original frame bytes are unchanged.
  - i_data=0 with ZERO_DROP=1 gives no busy, no push, no ovr.
- rst asserted during the third data push:
  - All outputs 0 immediately.
  - A new i_valid after rst release sends a complete fresh frame.
